inv_round_ctrl: RTL and testbench
=================================

# inv_round_ctrl

- Control sequencer for the AES inverse cipher (decryption).
- On `start`, it issues one datapath step per round, with round-key index counting down from NR to 0, over a valid/ready handshake.
- It pulses `done` when the final round has been accepted.
- Sits between the decryption top-level control and the inverse-round datapath / round-key store.

## Interface
Parameters:
- `NR`, 10: number of AES rounds (10/12/14 for 128/192/256-bit keys); legal range 2 ≤ NR < 2**ROUND_BITS.
- `ROUND_BITS`, 4: width of the round index.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one block decryption; sampled only in IDLE.
- `step_ready`  in  1  datapath accepts the current step.
- `step_valid`  out  1  step presented on `round_idx`/`step_op`.
- `round_idx`  out  ROUND_BITS  round-key index for the current step.
- `step_op`  out  2  step operation: 00 NONE, 01 ARK_ONLY, 10 FULL, 11 LAST.
- `busy`  out  1  high from the cycle after `start` accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse after the final step is accepted.
- `abort`  in  1  present only with `INV_ROUND_CTRL_ABORT_EN`.

## Operation
States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE
  - All outputs 0.
  - `start`=1 → INIT, with the round counter loaded to NR.
- INIT
  - `step_valid`=1, `step_op`=ARK_ONLY, `round_idx`=NR.
  - On acceptance: counter decrements; next state is ROUND.
- ROUND
  - `step_op`=FULL (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns); `round_idx`=counter (NR-1 down to 1).
  - On acceptance: counter decrements.
  - If the counter was 1 at acceptance → FINAL.
- FINAL
  - `step_op`=LAST (no InvMixColumns), `round_idx`=0.
  - On acceptance → DONE.
- DONE
  - `done`=1 and `busy`=1 for one cycle, then unconditionally → IDLE.
  - `start` is ignored in DONE.

Handshake:
- Acceptance means `step_valid` && `step_ready` at a rising edge.
- While `step_valid`=1 and `step_ready`=0, `round_idx` and `step_op` hold stable.
- `step_valid` never drops without acceptance, except on reset or abort.
- `step_ready` is a don't-care when `step_valid`=0.

Counter:
- ROUND_BITS-wide, counts down only, decrements only on acceptance.
- Never wraps: it stops at 0, because FINAL has no decrement.
- `start` while `busy` is ignored; no re-entry and no counter reload.

Reset:
- Asserting `n_rst` at any point forces IDLE, counter = 0, and all outputs = 0 immediately.
- No `done` is produced for an interrupted block.

## Timing
- `start` accepted at edge 0 → `step_valid`=1 (INIT, idx NR) during cycle 1.
- With `step_ready` tied high: one step per cycle, so steps occupy cycles 1..NR+1, `done` in cycle NR+2, and IDLE in cycle NR+3.
  - Minimum start-to-start spacing is NR+3 cycles.
- Each cycle of `step_ready`=0 while valid adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state only; there is no combinational path from `step_ready` or `start` to any output.

## Configuration
- Macro `INV_ROUND_CTRL_ABORT_EN`.
- Defined:
  - `abort` port exists.
  - `abort`=1 in INIT/ROUND/FINAL → IDLE at the next edge, counter cleared, no `done`.
  - `abort` has priority over acceptance in the same cycle.
  - `abort` in IDLE/DONE has no effect.
- Undefined: no `abort` port; the FSM always runs to completion.

## Structure
- Shared package `aes_pkg`:
  - `step_op_t` enum (NONE/ARK_ONLY/FULL/LAST = 0..3);
  - `inv_round_state_t` enum;
  - the NR constants `AES128_NR`=10, `AES192_NR`=12, `AES256_NR`=14.
- One sub-module is natural: `round_down_counter`.
  - Parameterised width; inputs load, load_val, dec; output count.
  - No wrap: it holds at 0.
- The FSM and output decode stay in `inv_round_ctrl`.

## Test plan
- Reset → `step_valid`=0, `round_idx`=0, `step_op`=00, `busy`=0, `done`=0; they stay 0 for 5 cycles with `start`=0.
- NR=10, `step_ready`=1, `start` pulse at cycle 0:
  - expected steps (idx, op): (10, ARK_ONLY) in cycle 1, (9..1, FULL) in cycles 2–10, (0, LAST) in cycle 11;
  - `done` in cycle 12, and only there.
- Backpressure: `step_ready`=0 for 3 cycles while at idx 5 → `round_idx`=5 and `step_op`=FULL hold stable; `done` arrives at cycle 15.
- `start` pulsed at idx 7 and again during the DONE cycle → both ignored: a single step sequence and a single `done`.
- `n_rst` asserted mid-block at idx 6 → all outputs 0 immediately; the next `start` restarts at idx 10 with ARK_ONLY.
- With `INV_ROUND_CTRL_ABORT_EN`: `abort` together with acceptance at idx 4 → IDLE next cycle, no `done`, no step at idx 3.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types and round-count constants for the inverse-cipher control path
package aes_pkg;
  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;
  typedef enum logic [1:0] {NONE = 2'd0, ARK_ONLY = 2'd1, FULL = 2'd2, LAST = 2'd3} step_op_t;
  typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_INIT = 3'd1, ST_ROUND = 3'd2, ST_FINAL = 3'd3, ST_DONE = 3'd4} inv_round_state_t;
endpackage

// File: rtl/inv_round_ctrl_if.sv
// inv_round_ctrl_if: step handshake bus (step_valid/step_ready, round_idx, step_op); master = sequencer, slave = datapath
interface inv_round_ctrl_if #(parameter int ROUND_BITS = 4);
  logic step_valid;
  logic step_ready;
  logic [ROUND_BITS-1:0] round_idx;
  logic [1:0] step_op;
  modport master(output step_valid, round_idx, step_op, input step_ready);
  modport slave(input step_valid, round_idx, step_op, output step_ready);
endinterface

// File: rtl/inv_round_ctrl_round_down_counter.sv
// round_down_counter: loadable down counter (clk, n_rst, load, load_val, dec -> count) that holds at 0 instead of wrapping
module round_down_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
endmodule

// File: rtl/inv_round_ctrl.sv
// inv_round_ctrl: AES inverse-cipher round sequencer (clk, n_rst, start, busy, done, step bus master; abort port with INV_ROUND_CTRL_ABORT_EN)
module inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int ROUND_BITS = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
`ifdef INV_ROUND_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  output logic done,
  inv_round_ctrl_if.master step
);
  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] INIT  = ST_INIT;
  localparam logic [2:0] ROUND = ST_ROUND;
  localparam logic [2:0] FINAL = ST_FINAL;
  localparam logic [2:0] DONE  = ST_DONE;
  logic [2:0] state, nxt;
  logic [ROUND_BITS-1:0] cnt;
  logic active, acc, abt;
`ifdef INV_ROUND_CTRL_ABORT_EN
  assign abt = abort && active;
`else
  assign abt = 1'b0;
`endif
  assign active = state == INIT || state == ROUND || state == FINAL;
  assign acc = active && step.step_ready;
  round_down_counter #(.W(ROUND_BITS)) u_cnt (
    .clk(clk),
    .n_rst(n_rst),
    .load((state == IDLE && start) || abt),
    .load_val(state == IDLE ? ROUND_BITS'(NR) : '0),
    .dec(acc && (state == INIT || state == ROUND)),
    .count(cnt)
  );
  always_comb begin
    nxt = abt ? IDLE :
          state == IDLE  ? (start ? INIT : IDLE) :
          state == INIT  ? (acc ? ROUND : INIT) :
          state == ROUND ? (acc && cnt == ROUND_BITS'(1) ? FINAL : ROUND) :
          state == FINAL ? (acc ? DONE : FINAL) : IDLE;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  assign step.step_valid = active;
  assign step.round_idx = active ? cnt : '0;
  assign step.step_op = state == INIT ? ARK_ONLY : state == ROUND ? FULL : state == FINAL ? LAST : NONE;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_inv_round_ctrl.sv
// tb_inv_round_ctrl: table-driven directed checks of inv_round_ctrl with NR=10
module tb_inv_round_ctrl;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic st, rdy, ab, v;
    logic [3:0] idx;
    logic [1:0] op;
    logic b, d;
  } vec_t;
  vec_t q[$];
  inv_round_ctrl_if #(.ROUND_BITS(4)) bus();
  inv_round_ctrl #(.NR(10), .ROUND_BITS(4)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
`ifdef INV_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .step(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_outs(input string nm, input logic v, input logic [3:0] idx, input logic [1:0] op, input logic b, input logic d);
    chk({nm, ".valid"}, 32'(bus.step_valid), 32'(v));
    chk({nm, ".idx"}, 32'(bus.round_idx), 32'(idx));
    chk({nm, ".op"}, 32'(bus.step_op), 32'(op));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".done"}, 32'(done), 32'(d));
  endtask
  function automatic void add(input logic st, input logic rdy, input logic ab, input logic v, input logic [3:0] idx, input logic [1:0] op, input logic b, input logic d);
    q.push_back('{st, rdy, ab, v, idx, op, b, d});
  endfunction
  // nominal block with ready high; extra start pulses at rows sa/sb; rows 0..last
  function automatic void nominal(input int sa, input int sb, input int last, input int ab_row);
    for (int k = 0; k <= last; k++) begin
      logic [1:0] op;
      op = k == 1 ? 2'd1 : (k >= 2 && k <= 10) ? 2'd2 : k == 11 ? 2'd3 : 2'd0;
      add(k == 0 || k == sa || k == sb, 1'b1, k == ab_row, k >= 1 && k <= 11,
          (k >= 1 && k <= 10) ? 4'(11 - k) : 4'd0, op, k >= 1 && k <= 12, k == 12);
    end
  endfunction
  task automatic run(input string nm);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk_outs($sformatf("%s[%0d]", nm, i), q[i].v, q[i].idx, q[i].op, q[i].b, q[i].d);
      start = q[i].st;
      bus.step_ready = q[i].rdy;
      abort = q[i].ab;
    end
    q.delete();
  endtask
  initial begin
    bus.step_ready = 1'b0;
    #1 chk_outs("in_reset", 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    run("idle");
    nominal(-1, -1, 13, -1);
    run("nominal");
    for (int k = 0; k <= 16; k++) begin
      logic [1:0] op;
      logic [3:0] idx;
      op = k == 1 ? 2'd1 : (k >= 2 && k <= 13) ? 2'd2 : k == 14 ? 2'd3 : 2'd0;
      idx = (k >= 1 && k <= 5) ? 4'(11 - k) : (k >= 6 && k <= 9) ? 4'd5 : (k >= 10 && k <= 13) ? 4'(14 - k) : 4'd0;
      add(k == 0, !(k >= 6 && k <= 8), 1'b0, k >= 1 && k <= 14, idx, op, k >= 1 && k <= 15, k == 15);
    end
    run("backpressure");
    nominal(4, 12, 14, -1);
    run("start_ignored");
    nominal(-1, -1, 5, -1);
    run("pre_reset");
    #2 n_rst = 1'b0;
    #1 chk_outs("async_reset", 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("held_reset", 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    n_rst = 1'b1;
    nominal(-1, -1, 13, -1);
    run("after_reset");
`ifdef INV_ROUND_CTRL_ABORT_EN
    nominal(-1, -1, 7, 7);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    run("abort");
    nominal(-1, -1, 13, -1);
    run("after_abort");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
